// File: rtl/exc_ctrl.sv
// ============================================================================
// Module   : exc_ctrl
// Brief    : MEM-stage exception arbiter. It picks one exception by fixed
//            priority and issues a one-cycle report, flush and redirect PC,
//            then blanks further reports while the pipeline refills.
//            Optional macro EXC_CTRL_TIMER_INT_EN adds timer_int_i, which is
//            ORed into the IP7 pending term.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          BLANK_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [7:0]  excflags_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
`ifdef EXC_CTRL_TIMER_INT_EN
  input  logic        timer_int_i,
`endif
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic        busy_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REPORT = 2'd1;
  localparam logic [1:0] S_BLANK  = 2'd2;

  localparam logic [4:0]  c_addr_status = 5'd12;
  localparam logic [4:0]  c_addr_cause  = 5'd13;
  localparam logic [4:0]  c_addr_epc    = 5'd14;
  localparam logic [31:0] c_code_eret   = 32'he;
  localparam logic [2:0]  c_blank_load  = 3'(BLANK_CYCLES - 1);

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;

  logic [31:0] w_eff_status;
  logic [31:0] w_eff_cause;
  logic [31:0] w_eff_epc;
  logic [7:0]  w_ip;
  logic        w_int_pend;
  logic        w_hit;
  logic        w_detect;
  logic [31:0] w_code;
  logic [31:0] w_bad_addr;
  logic        w_unused_bits;

  // The WB-stage mtc0 has not reached CP0 yet, so its value is forwarded here.
  always_comb begin
    w_eff_status = cp0_status_i;
    w_eff_cause  = cp0_cause_i;
    w_eff_epc    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == c_addr_status) w_eff_status = wb_cp0_wdata_i;
      if (wb_cp0_waddr_i == c_addr_cause)  w_eff_cause[9:8] = wb_cp0_wdata_i[9:8];
      if (wb_cp0_waddr_i == c_addr_epc)    w_eff_epc = wb_cp0_wdata_i;
    end
  end

`ifdef EXC_CTRL_TIMER_INT_EN
  assign w_ip = {w_eff_cause[15] | timer_int_i, w_eff_cause[14:8]};
`else
  assign w_ip = w_eff_cause[15:8];
`endif

  assign w_int_pend = w_eff_status[0] & ~w_eff_status[1] & (|(w_eff_status[15:8] & w_ip));

  always_comb begin
    w_hit      = 1'b1;
    w_code     = 32'h0;
    w_bad_addr = 32'h0;
    if (w_int_pend)          w_code = 32'h1;
    else if (excflags_i[0]) begin
      w_code     = 32'h4;
      w_bad_addr = pc_i;
    end
    else if (excflags_i[1])  w_code = 32'ha;
    else if (excflags_i[2])  w_code = 32'h8;
    else if (excflags_i[3])  w_code = 32'h9;
    else if (excflags_i[4])  w_code = 32'hc;
    else if (excflags_i[5]) begin
      w_code     = 32'h4;
      w_bad_addr = mem_addr_i;
    end
    else if (excflags_i[6]) begin
      w_code     = 32'h5;
      w_bad_addr = mem_addr_i;
    end
    else if (excflags_i[7])  w_code = c_code_eret;
    else                     w_hit  = 1'b0;
  end

  assign w_detect = (r_state == S_IDLE) & valid_i & ~stall_i & w_hit;

  // Report fields are zero in every cycle except the single report cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state             <= S_IDLE;
      r_cnt               <= 3'd0;
      excepttype_o        <= 32'h0;
      current_inst_addr_o <= 32'h0;
      is_in_delayslot_o   <= 1'b0;
      bad_addr_o          <= 32'h0;
      flush_o             <= 1'b0;
      newpc_o             <= 32'h0;
    end else begin
      excepttype_o        <= 32'h0;
      current_inst_addr_o <= 32'h0;
      is_in_delayslot_o   <= 1'b0;
      bad_addr_o          <= 32'h0;
      flush_o             <= 1'b0;
      newpc_o             <= 32'h0;
      case (r_state)
        S_IDLE: begin
          if (w_detect) begin
            excepttype_o        <= w_code;
            current_inst_addr_o <= pc_i;
            is_in_delayslot_o   <= in_delayslot_i;
            bad_addr_o          <= w_bad_addr;
            flush_o             <= 1'b1;
            newpc_o             <= (w_code == c_code_eret) ? w_eff_epc : EXC_VECTOR;
            r_state             <= S_REPORT;
          end
        end
        S_REPORT: begin
          r_state <= S_BLANK;
          r_cnt   <= c_blank_load;
        end
        S_BLANK: begin
          if (r_cnt == 3'd0) r_state <= S_IDLE;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (r_state != S_IDLE);

  assign w_unused_bits = &{1'b0, w_eff_status[31:16], w_eff_status[7:2],
                           w_eff_cause[31:16], w_eff_cause[7:0]};

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl.sv
// ============================================================================
// Module   : tb_exc_ctrl
// Brief    : Scoreboard bench for exc_ctrl with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exc_ctrl;

  typedef struct {
    logic [31:0] code;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [31:0] newpc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        valid_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [7:0]  excflags_i;
  logic [31:0] mem_addr_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_wdata_i;
`ifdef EXC_CTRL_TIMER_INT_EN
  logic        timer_int_i = 1'b0;
`endif
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic [31:0] newpc_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  localparam logic [31:0] VEC = 32'hBFC00380;

  exc_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_i             (stall_i),
    .valid_i             (valid_i),
    .pc_i                (pc_i),
    .in_delayslot_i      (in_delayslot_i),
    .excflags_i          (excflags_i),
    .mem_addr_i          (mem_addr_i),
    .cp0_status_i        (cp0_status_i),
    .cp0_cause_i         (cp0_cause_i),
    .cp0_epc_i           (cp0_epc_i),
    .wb_cp0_we_i         (wb_cp0_we_i),
    .wb_cp0_waddr_i      (wb_cp0_waddr_i),
    .wb_cp0_wdata_i      (wb_cp0_wdata_i),
`ifdef EXC_CTRL_TIMER_INT_EN
    .timer_int_i         (timer_int_i),
`endif
    .excepttype_o        (excepttype_o),
    .current_inst_addr_o (current_inst_addr_o),
    .is_in_delayslot_o   (is_in_delayslot_o),
    .bad_addr_o          (bad_addr_o),
    .flush_o             (flush_o),
    .newpc_o             (newpc_o),
    .busy_o              (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every flush cycle must match the oldest expected report.
  always @(negedge clk) begin
    if (flush_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_report", excepttype_o, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("excepttype", excepttype_o, e.code);
        chk("inst_addr", current_inst_addr_o, e.pc);
        chk("delayslot", {31'h0, is_in_delayslot_o}, {31'h0, e.ds});
        chk("bad_addr", bad_addr_o, e.bad);
        chk("newpc", newpc_o, e.newpc);
      end
    end else begin
      chk("idle_excepttype", excepttype_o, 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_i = 0; valid_i = 0; pc_i = 0; in_delayslot_i = 0; excflags_i = 0;
    mem_addr_i = 0; cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
    wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_wdata_i = 0;
  endtask

  task automatic expect_rep(input logic [31:0] code, input logic [31:0] pc,
                            input logic ds, input logic [31:0] bad, input logic [31:0] npc);
    exp_t e;
    e.code = code; e.pc = pc; e.ds = ds; e.bad = bad; e.newpc = npc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy_o; i++) step();
    chk("wait_idle", {31'h0, busy_o}, 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_excepttype"}, excepttype_o, 32'h0);
    chk({tag, "_inst_addr"}, current_inst_addr_o, 32'h0);
    chk({tag, "_bad_addr"}, bad_addr_o, 32'h0);
    chk({tag, "_flush_ds_busy"}, {29'h0, flush_o, is_in_delayslot_o, busy_o}, 32'h0);
    chk({tag, "_newpc"}, newpc_o, 32'h0);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    step(); step();
    chk_all_zero("reset");
    rst = 0;
    step();

    // Syscall, then BLANK occupancy of three cycles.
    pc_i = 32'hBFC00100; excflags_i = 8'h04; valid_i = 1;
    expect_rep(32'h8, 32'hBFC00100, 0, 32'h0, VEC);
    step();
    chk("syscall_busy_report", {31'h0, busy_o}, 32'h1);
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("syscall_busy_blank", {31'h0, busy_o}, 32'h1);
    end
    step();
    chk("syscall_busy_done", {31'h0, busy_o}, 32'h0);

    // Load misaligned in a delay slot.
    pc_i = 32'h80001000; mem_addr_i = 32'h80000003; excflags_i = 8'h20;
    in_delayslot_i = 1; valid_i = 1;
    expect_rep(32'h4, 32'h80001000, 1, 32'h80000003, VEC);
    step(); clear_inputs(); wait_idle();

    // Interrupt via forwarded Cause IP0 beats overflow.
    pc_i = 32'h80002000; excflags_i = 8'h10; valid_i = 1;
    cp0_status_i = 32'h00000101; cp0_cause_i = 32'h0;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd13; wb_cp0_wdata_i = 32'h00000100;
    expect_rep(32'h1, 32'h80002000, 0, 32'h0, VEC);
    step(); clear_inputs(); wait_idle();

    // Interrupt via forwarded Status IM0/IE.
    pc_i = 32'h80002100; excflags_i = 8'h10; valid_i = 1;
    cp0_status_i = 32'h00000001; cp0_cause_i = 32'h00000100;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd12; wb_cp0_wdata_i = 32'h00000101;
    expect_rep(32'h1, 32'h80002100, 0, 32'h0, VEC);
    step(); clear_inputs(); wait_idle();

    // Cause forwarding replaces only bits 9:8, so IP7 survives a zero write.
    pc_i = 32'h80002200; excflags_i = 8'h02; valid_i = 1;
    cp0_status_i = 32'h00008001; cp0_cause_i = 32'h00008000;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd13; wb_cp0_wdata_i = 32'h0;
    expect_rep(32'h1, 32'h80002200, 0, 32'h0, VEC);
    step(); clear_inputs(); wait_idle();

    // eret with EXL=1 masks interrupts; EPC forwarded from WB.
    pc_i = 32'h80003000; excflags_i = 8'h80; valid_i = 1;
    cp0_status_i = 32'h0000FF03; cp0_cause_i = 32'h0000FF00; cp0_epc_i = 32'h100;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_wdata_i = 32'h200;
    expect_rep(32'he, 32'h80003000, 0, 32'h0, 32'h200);
    step(); clear_inputs(); wait_idle();

    // Break held under stall: nothing until stall falls.
    pc_i = 32'h80004000; excflags_i = 8'h08; valid_i = 1; stall_i = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_no_flush", {31'h0, flush_o}, 32'h0);
    end
    stall_i = 0; pc_i = 32'h80004004;
    expect_rep(32'h9, 32'h80004004, 0, 32'h0, VEC);
    step();
    // A flagged instruction during REPORT/BLANK is ignored.
    pc_i = 32'h80004008;
    step(); step(); step();
    clear_inputs(); wait_idle();

    // Interrupt raised during BLANK is reported on the first IDLE cycle.
    pc_i = 32'h80005000; excflags_i = 8'h04; valid_i = 1;
    expect_rep(32'h8, 32'h80005000, 0, 32'h0, VEC);
    step();
    excflags_i = 8'h0; pc_i = 32'h80005004;
    cp0_status_i = 32'h00000101; cp0_cause_i = 32'h00000100;
    expect_rep(32'h1, 32'h80005004, 0, 32'h0, VEC);
    for (int i = 0; i < 5; i++) step();
    chk("blank_int_busy", {31'h0, busy_o}, 32'h1);
    clear_inputs(); wait_idle();

    // Reset during BLANK, then a normal report afterwards.
    pc_i = 32'h80000002; excflags_i = 8'h01; valid_i = 1;
    expect_rep(32'h4, 32'h80000002, 0, 32'h80000002, VEC);
    step(); clear_inputs();
    step();
    chk("pre_reset_busy", {31'h0, busy_o}, 32'h1);
    rst = 1;
    step();
    chk_all_zero("midreset");
    rst = 0;
    pc_i = 32'h80006000; mem_addr_i = 32'h80000011; excflags_i = 8'h40; valid_i = 1;
    expect_rep(32'h5, 32'h80006000, 0, 32'h80000011, VEC);
    step(); clear_inputs(); wait_idle();

    step(); step();
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
